// File: rtl/pmem_arbiter_if.sv
// Line-port bundle between the two caches, the arbiter and the physical-memory side.
// The arbiter uses the slave view; the cache/memory environment uses the master view.
interface pmem_arbiter_if #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) ();
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata;
   logic [LINE_W-1:0] m_rdata;
   logic              m_resp;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
      output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Serialising arbiter between icache/dcache line ports and one physical-memory line port.
// Round-robin on contention, or fixed dcache priority when ARB_MODE is 1.
module pmem_arbiter #(
   parameter int LINE_W   = 256,
   parameter int ADDR_W   = 32,
   parameter int ARB_MODE = 0
) (
   input logic           clk,
   input logic           rst,
   pmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
   typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

   state_t            state_r, next_state_s;
   grant_t            last_grant_r;
   logic              grant_i_s, grant_d_s, d_req_s;
   logic              m_read_r, m_write_r, i_resp_r, d_resp_r;
   logic [ADDR_W-1:0] m_addr_r;
   logic [LINE_W-1:0] m_wdata_r, i_rdata_r, d_rdata_r;

   // Grant decision and next-state selection.
   always_comb begin
      next_state_s = state_r;
      grant_i_s    = 1'b0;
      grant_d_s    = 1'b0;
      d_req_s      = bus.d_read | bus.d_write;
      case (state_r)
         IDLE: begin
            if (bus.i_read && d_req_s) begin
               // On contention the side that did not win last time goes first.
               if ((ARB_MODE == 32'sd1) || (last_grant_r == GRANT_I)) begin
                  grant_d_s = 1'b1;
               end else begin
                  grant_i_s = 1'b1;
               end
            end else if (bus.i_read) begin
               grant_i_s = 1'b1;
            end else if (d_req_s) begin
               grant_d_s = 1'b1;
            end else begin
               grant_i_s = 1'b0;
            end
            if (grant_d_s) begin
               next_state_s = BUSY_D;
            end else if (grant_i_s) begin
               next_state_s = BUSY_I;
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.m_resp) begin
               next_state_s = RESP;
            end else begin
               next_state_s = state_r;
            end
         end
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State, registered memory request and registered cache responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_I;
         m_read_r     <= 1'b0;
         m_write_r    <= 1'b0;
         m_addr_r     <= {ADDR_W{1'b0}};
         m_wdata_r    <= {LINE_W{1'b0}};
         i_rdata_r    <= {LINE_W{1'b0}};
         d_rdata_r    <= {LINE_W{1'b0}};
         i_resp_r     <= 1'b0;
         d_resp_r     <= 1'b0;
      end else begin
         state_r <= next_state_s;
         case (state_r)
            IDLE: begin
               if (grant_d_s) begin
                  // A simultaneous read+write from the dcache is treated as a writeback.
                  m_addr_r     <= {bus.d_addr[ADDR_W-1:5], 5'b0};
                  m_wdata_r    <= bus.d_wdata;
                  m_write_r    <= bus.d_write;
                  m_read_r     <= ~bus.d_write;
                  last_grant_r <= GRANT_D;
               end else if (grant_i_s) begin
                  m_addr_r     <= {bus.i_addr[ADDR_W-1:5], 5'b0};
                  m_write_r    <= 1'b0;
                  m_read_r     <= 1'b1;
                  last_grant_r <= GRANT_I;
               end
            end
            BUSY_I: begin
               if (bus.m_resp) begin
                  i_rdata_r <= bus.m_rdata;
                  m_read_r  <= 1'b0;
                  m_write_r <= 1'b0;
                  i_resp_r  <= 1'b1;
               end
            end
            BUSY_D: begin
               if (bus.m_resp) begin
                  if (m_read_r) begin
                     d_rdata_r <= bus.m_rdata;
                  end
                  m_read_r  <= 1'b0;
                  m_write_r <= 1'b0;
                  d_resp_r  <= 1'b1;
               end
            end
            RESP: begin
               i_resp_r <= 1'b0;
               d_resp_r <= 1'b0;
            end
            default: begin
               m_read_r  <= 1'b0;
               m_write_r <= 1'b0;
               i_resp_r  <= 1'b0;
               d_resp_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m_read  = m_read_r;
   assign bus.m_write = m_write_r;
   assign bus.m_addr  = m_addr_r;
   assign bus.m_wdata = m_wdata_r;
   assign bus.i_rdata = i_rdata_r;
   assign bus.d_rdata = d_rdata_r;
   assign bus.i_resp  = i_resp_r;
   assign bus.d_resp  = d_resp_r;
endmodule
